// File: rtl/disp_check_pkg.sv
// Shared constants and types for the display-output frame checker.
package disp_check_pkg;

    localparam int unsigned PIX_W       = 24;
    localparam int unsigned CRC_W       = 32;
    localparam int unsigned LINE_W_W    = 12;
    localparam int unsigned LINE_CNT_W  = 11;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [CRC_W-1:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [CRC_W-1:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/disp_crc32_d24.sv
// Combinational next-CRC for one 24-bit pixel: the serial MSB-first LFSR unrolled 24 times.
module disp_crc32_d24
    import disp_check_pkg::*;
(
    input  logic [CRC_W-1:0] i_crc,
    input  logic [PIX_W-1:0] i_data,
    output logic [CRC_W-1:0] o_crc_c
);

    always_comb begin
        o_crc_c = i_crc;
        for (int i = int'(PIX_W) - 1; i >= 0; i--) begin
            if (o_crc_c[CRC_W-1] ^ i_data[i]) begin
                o_crc_c = {o_crc_c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                o_crc_c = {o_crc_c[CRC_W-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/disp_frame_check.sv
// Pixel-output monitor: per-frame line width/count, CRC-32 of active pixels,
// frame counter and sticky geometry errors, all in the DCLK domain.
module disp_frame_check
    import disp_check_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned V_ACTIVE = 768
) (
    input  logic                   DCLK,
    input  logic                   DRST,
    input  logic [7:0]             DSP_R,
    input  logic [7:0]             DSP_G,
    input  logic [7:0]             DSP_B,
    input  logic                   DSP_DE,
    input  logic                   DSP_HSYNC_X,
    input  logic                   DSP_VSYNC_X,
    input  logic                   CHK_EN,
    input  logic                   ERR_CLR,
    output logic                   FRAME_DONE,
    output logic [CRC_W-1:0]       FRAME_CRC,
    output logic [LINE_W_W-1:0]    LINE_W,
    output logic [LINE_CNT_W-1:0]  LINE_CNT,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT,
    output logic                   ERR_W,
    output logic                   ERR_H
);

    localparam logic [LINE_W_W-1:0]   H_EXP = LINE_W_W'(H_ACTIVE);
    localparam logic [LINE_CNT_W-1:0] V_EXP = LINE_CNT_W'(V_ACTIVE);

    state_t                  r_state;
    logic                    r_vs_prev;
    logic                    r_de_prev;
    logic                    r_skip;       // open line cut by vsync: ignore until DE drops
    logic [LINE_W_W-1:0]     r_wcnt;
    logic [LINE_CNT_W-1:0]   r_lcnt;
    logic [CRC_W-1:0]        r_crc;
    logic [CRC_W-1:0]        r_crc_line;   // CRC at the last completed line

    pixel_t                  w_pix;
    logic [CRC_W-1:0]        w_crc_next;
    logic                    w_vs_fall;
    logic                    w_de_fall;
    logic                    w_run;
    logic                    w_line_end;
    logic                    w_frame_close;
    logic                    w_set_w;
    logic                    w_set_h;
    logic [LINE_W_W-1:0]     w_wcnt_inc;
    logic [LINE_CNT_W-1:0]   w_lcnt_inc;
    logic [LINE_CNT_W-1:0]   w_lcnt_close;
    logic [CRC_W-1:0]        w_crc_close;
    logic                    w_unused_hsync;

    assign w_unused_hsync = DSP_HSYNC_X;
    assign w_pix          = '{r: DSP_R, g: DSP_G, b: DSP_B};

    disp_crc32_d24 u_crc (
        .i_crc   (r_crc),
        .i_data  (w_pix),
        .o_crc_c (w_crc_next)
    );

    assign w_vs_fall     = ~DSP_VSYNC_X & r_vs_prev;
    assign w_de_fall     = ~DSP_DE & r_de_prev;
    assign w_run         = (r_state == RUN) & CHK_EN;
    assign w_line_end    = w_run & w_de_fall & ~r_skip;
    assign w_frame_close = w_run & w_vs_fall;

    assign w_wcnt_inc   = (r_wcnt == '1) ? r_wcnt : r_wcnt + LINE_W_W'(1);
    assign w_lcnt_inc   = (r_lcnt == '1) ? r_lcnt : r_lcnt + LINE_CNT_W'(1);
    assign w_lcnt_close = w_line_end ? w_lcnt_inc : r_lcnt;
    // A line still open at vsync is dropped, so the frame CRC rolls back to the last line end.
    assign w_crc_close  = DSP_DE ? r_crc_line : r_crc;

    assign w_set_w = (w_line_end & (r_wcnt != H_EXP)) | (w_frame_close & DSP_DE);
    assign w_set_h = w_frame_close & (w_lcnt_close != V_EXP);

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            r_state    <= IDLE;
            r_vs_prev  <= 1'b1;
            r_de_prev  <= 1'b1;
            r_skip     <= 1'b0;
            r_wcnt     <= '0;
            r_lcnt     <= '0;
            r_crc      <= CRC_INIT;
            r_crc_line <= CRC_INIT;
            FRAME_DONE <= 1'b0;
            FRAME_CRC  <= '0;
            LINE_W     <= '0;
            LINE_CNT   <= '0;
            FRAME_CNT  <= '0;
            ERR_W      <= 1'b0;
            ERR_H      <= 1'b0;
        end else begin
            r_vs_prev  <= DSP_VSYNC_X;
            r_de_prev  <= DSP_DE;
            FRAME_DONE <= 1'b0;
            ERR_W      <= w_set_w | (ERR_W & ~ERR_CLR);
            ERR_H      <= w_set_h | (ERR_H & ~ERR_CLR);
            case (r_state)
                IDLE: begin
                    r_wcnt     <= '0;
                    r_lcnt     <= '0;
                    r_crc      <= CRC_INIT;
                    r_crc_line <= CRC_INIT;
                    if (CHK_EN && w_vs_fall) begin
                        r_state <= RUN;
                        r_skip  <= DSP_DE;
                    end
                end
                RUN: begin
                    if (!CHK_EN) begin
                        r_state    <= IDLE;
                        r_wcnt     <= '0;
                        r_lcnt     <= '0;
                        r_crc      <= CRC_INIT;
                        r_crc_line <= CRC_INIT;
                    end else if (w_frame_close) begin
                        FRAME_DONE <= 1'b1;
                        FRAME_CRC  <= w_crc_close;
                        LINE_CNT   <= w_lcnt_close;
                        FRAME_CNT  <= FRAME_CNT + FRAME_CNT_W'(1);
                        if (w_line_end) begin
                            LINE_W <= r_wcnt;
                        end
                        r_wcnt     <= '0;
                        r_lcnt     <= '0;
                        r_crc      <= CRC_INIT;
                        r_crc_line <= CRC_INIT;
                        r_skip     <= DSP_DE;
                    end else begin
                        if (DSP_DE && !r_skip) begin
                            r_wcnt <= w_wcnt_inc;
                            r_crc  <= w_crc_next;
                        end
                        if (w_line_end) begin
                            LINE_W     <= r_wcnt;
                            r_lcnt     <= w_lcnt_inc;
                            r_wcnt     <= '0;
                            r_crc_line <= r_crc;
                        end
                        if (!DSP_DE) begin
                            r_skip <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disp_frame_check.sv
// Scoreboard bench for disp_frame_check at a 4x2 geometry.
module tb_disp_frame_check;

    localparam int unsigned H = 4;
    localparam int unsigned V = 2;
    localparam logic [31:0] POLY = 32'h04C1_1DB7;
    localparam logic [31:0] INIT = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        drst;
    logic [7:0]  dsp_r, dsp_g, dsp_b;
    logic        dsp_de, dsp_hs_x, dsp_vs_x, chk_en, err_clr;
    logic        frame_done;
    logic [31:0] frame_crc;
    logic [11:0] line_w;
    logic [10:0] line_cnt;
    logic [15:0] frame_cnt;
    logic        err_w, err_h;

    always #5 clk = ~clk;

    disp_frame_check #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .DCLK(clk), .DRST(drst), .DSP_R(dsp_r), .DSP_G(dsp_g), .DSP_B(dsp_b),
        .DSP_DE(dsp_de), .DSP_HSYNC_X(dsp_hs_x), .DSP_VSYNC_X(dsp_vs_x),
        .CHK_EN(chk_en), .ERR_CLR(err_clr), .FRAME_DONE(frame_done),
        .FRAME_CRC(frame_crc), .LINE_W(line_w), .LINE_CNT(line_cnt),
        .FRAME_CNT(frame_cnt), .ERR_W(err_w), .ERR_H(err_h)
    );

    typedef struct {
        logic [31:0] crc;
        logic [10:0] lcnt;
        logic [15:0] fcnt;
        logic        ew;
        logic        eh;
    } frame_exp_t;

    typedef struct {
        logic [11:0] w;
        logic        ew;
        logic        chk;
    } line_exp_t;

    frame_exp_t frame_q[$];
    line_exp_t  line_q[$];

    int n_vec = 0;
    int n_err = 0;

    // bench reference model state
    logic        m_run = 1'b0;
    logic [31:0] m_crc = INIT;
    int          m_lcnt = 0;
    logic [15:0] m_fcnt = 16'h0;
    logic        m_ew = 1'b0;
    logic        m_eh = 1'b0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_crc = 32'h0;

    function automatic logic [31:0] crc_px(logic [31:0] c, logic [23:0] px);
        logic [31:0] s = c;
        logic        fb;
        for (int k = 0; k < 24; k++) begin
            fb = s[31] ^ px[23-k];
            s  = s << 1;
            if (fb) s = s ^ POLY;
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: detects DE falls from the driven inputs and pops on FRAME_DONE.
    logic mon_de_prev = 1'b0;
    logic mon_fall = 1'b0;
    always @(posedge clk) begin
        mon_fall    <= mon_de_prev & ~dsp_de;
        mon_de_prev <= dsp_de;
    end

    always @(negedge clk) begin
        line_exp_t  le;
        frame_exp_t fe;
        if (mon_fall) begin
            if (line_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL line_q: DE fall with no expected entry");
            end else begin
                le = line_q.pop_front();
                if (le.chk) begin
                    chk("LINE_W", 32'(line_w), 32'(le.w));
                    chk("ERR_W@line", 32'(err_w), 32'(le.ew));
                end
            end
        end
        if (frame_done) begin
            if (frame_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL frame_done: unexpected pulse, FRAME_CNT=0x%0h", frame_cnt);
            end else begin
                fe = frame_q.pop_front();
                chk("FRAME_CRC", frame_crc, fe.crc);
                chk("LINE_CNT", 32'(line_cnt), 32'(fe.lcnt));
                chk("FRAME_CNT", 32'(frame_cnt), 32'(fe.fcnt));
                chk("ERR_W@frame", 32'(err_w), 32'(fe.ew));
                chk("ERR_H", 32'(err_h), 32'(fe.eh));
            end
        end
    end

    task automatic line(input int n, input logic [23:0] start, input logic [23:0] step);
        logic [23:0] px = start;
        line_exp_t   le;
        for (int i = 0; i < n; i++) begin
            dsp_de = 1'b1;
            {dsp_r, dsp_g, dsp_b} = px;
            if (m_run) m_crc = crc_px(m_crc, px);
            px = px + step;
            tick();
        end
        dsp_de = 1'b0;
        {dsp_r, dsp_g, dsp_b} = 24'h0;
        if (m_run) begin
            m_ew = m_ew | (n != int'(H));
            m_lcnt++;
            le = '{w: 12'(n), ew: m_ew, chk: 1'b1};
        end else begin
            le = '{w: 12'h0, ew: 1'b0, chk: 1'b0};
        end
        line_q.push_back(le);
        tick();
        tick();
    endtask

    // vsync falling edge; de_open keeps DE high through the edge with a pixel that must be dropped
    task automatic vs(input logic clr, input logic de_open);
        frame_exp_t fe;
        line_exp_t  le;
        dsp_vs_x = 1'b0;
        err_clr  = clr;
        if (de_open) begin
            dsp_de = 1'b1;
            {dsp_r, dsp_g, dsp_b} = 24'hABCDEF;
        end
        if (m_run) begin
            m_ew  = de_open | (m_ew & ~clr);
            m_eh  = (m_lcnt != int'(V)) | (m_eh & ~clr);
            m_fcnt = m_fcnt + 16'd1;
            fe = '{crc: (ovr_en ? ovr_crc : m_crc), lcnt: 11'(m_lcnt), fcnt: m_fcnt, ew: m_ew, eh: m_eh};
            frame_q.push_back(fe);
            m_crc  = INIT;
            m_lcnt = 0;
        end else begin
            m_ew  = m_ew & ~clr;
            m_eh  = m_eh & ~clr;
            m_run = 1'b1;
        end
        ovr_en = 1'b0;
        tick();
        dsp_vs_x = 1'b1;
        err_clr  = 1'b0;
        if (de_open) begin
            dsp_de = 1'b0;
            {dsp_r, dsp_g, dsp_b} = 24'h0;
            le = '{w: 12'h0, ew: 1'b0, chk: 1'b0};
            line_q.push_back(le);
            tick();
        end
        tick();
    endtask

    task automatic clr_pulse;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_ew = 1'b0;
        m_eh = 1'b0;
        chk("ERR_W@clr", 32'(err_w), 32'h0);
        chk("ERR_H@clr", 32'(err_h), 32'h0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_FRAME_DONE"}, 32'(frame_done), 32'h0);
        chk({tag, "_FRAME_CRC"}, frame_crc, 32'h0);
        chk({tag, "_LINE_W"}, 32'(line_w), 32'h0);
        chk({tag, "_LINE_CNT"}, 32'(line_cnt), 32'h0);
        chk({tag, "_FRAME_CNT"}, 32'(frame_cnt), 32'h0);
        chk({tag, "_ERR_W"}, 32'(err_w), 32'h0);
        chk({tag, "_ERR_H"}, 32'(err_h), 32'h0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drst = 1'b1; chk_en = 1'b0; dsp_vs_x = 1'b1; dsp_hs_x = 1'b1;
        dsp_de = 1'b0; {dsp_r, dsp_g, dsp_b} = 24'h0; err_clr = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");
        drst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Three clean frames; the first vsync only opens
        vs(1'b0, 1'b0);
        for (int f = 0; f < 3; f++) begin
            line(4, 24'h000001, 24'h000001);
            line(4, 24'h000005, 24'h000001);
            if (f < 2) vs(1'b0, 1'b0);
        end
        vs(1'b0, 1'b0);

        // Long second line
        line(4, 24'h000010, 24'h000001);
        line(5, 24'h000020, 24'h000001);
        vs(1'b0, 1'b0);
        clr_pulse();

        // Three-line frames; clear coinciding with an ERR_H set
        for (int i = 0; i < 3; i++) line(4, 24'h100000, 24'h010101);
        vs(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) line(4, 24'h200000, 24'h000100);
        vs(1'b1, 1'b0);
        clr_pulse();

        // CRC-32/MPEG-2 check string "123456789" as three pixels
        line(3, 24'h313233, 24'h030303);
        ovr_en = 1'b1; ovr_crc = 32'h0376_E6E7;
        vs(1'b0, 1'b0);
        clr_pulse();

        // Vsync while DE is high, then a clean recovery frame
        line(4, 24'h0A0B0C, 24'h000003);
        dsp_de = 1'b1; {dsp_r, dsp_g, dsp_b} = 24'h555555; tick();
        {dsp_r, dsp_g, dsp_b} = 24'h666666; tick();
        vs(1'b0, 1'b1);
        line(4, 24'h000001, 24'h000001);
        line(4, 24'h000005, 24'h000001);
        vs(1'b0, 1'b0);
        clr_pulse();

        // Reset mid-line
        line(4, 24'h000001, 24'h000001);
        dsp_de = 1'b1; {dsp_r, dsp_g, dsp_b} = 24'h777777; tick();
        drst = 1'b1; tick();
        chk_reset_outputs("drst");
        drst = 1'b0;
        dsp_de = 1'b0; {dsp_r, dsp_g, dsp_b} = 24'h0;
        line_q.push_back('{w: 12'h0, ew: 1'b0, chk: 1'b0});
        m_run = 1'b0; m_crc = INIT; m_lcnt = 0; m_fcnt = 16'h0; m_ew = 1'b0; m_eh = 1'b0;
        tick();
        tick();
        line(4, 24'h000001, 24'h000001);
        vs(1'b0, 1'b0);
        line(4, 24'h000001, 24'h000001);
        line(4, 24'h000005, 24'h000001);
        vs(1'b0, 1'b0);

        // Empty frames until FRAME_CNT wraps 0xFFFF -> 0x0000
        for (int i = 0; i < 65535; i++) vs(1'b0, 1'b0);
        chk("FRAME_CNT_wrap", 32'(frame_cnt), 32'h0);

        repeat (4) tick();
        chk("frame_q_empty", 32'(frame_q.size()), 32'h0);
        chk("line_q_empty", 32'(line_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/disp_frame_check.md
# disp_frame_check

Downstream monitor for the display circuit's pixel output. It runs in the DCLK domain and watches DSP_R/G/B, DSP_DE, DSP_HSYNC_X and DSP_VSYNC_X. For every frame it measures active line width and line count, computes a CRC-32 over the active pixels, counts frames, and flags geometry errors. Simulation benches and on-board self-test use it to check a displayed frame without dumping it to a text file.

## Interface
Parameters:
- H_ACTIVE, 1024, expected DE-high cycles per line (XGA)
- V_ACTIVE, 768, expected lines per frame (XGA)

Ports:
- DCLK  in  1  pixel clock; the only clock
- DRST  in  1  reset, synchronous, active-high
- DSP_R / DSP_G / DSP_B  in  8 each  pixel data
- DSP_DE  in  1  data enable
- DSP_HSYNC_X  in  1  hsync, active-low; monitored only for future use, not checked
- DSP_VSYNC_X  in  1  vsync, active-low; frame boundary
- CHK_EN  in  1  monitor enable (level)
- ERR_CLR  in  1  one-cycle pulse; clears the sticky errors
- FRAME_DONE  out  1  one-cycle pulse when frame results are latched
- FRAME_CRC  out  32  CRC of the last completed frame
- LINE_W  out  12  width of the last completed line
- LINE_CNT  out  11  line count of the last completed frame
- FRAME_CNT  out  16  number of completed frames
- ERR_W  out  1  sticky; a line width differed from H_ACTIVE
- ERR_H  out  1  sticky; a frame line count differed from V_ACTIVE

## Operation
- Pixel word is {DSP_R, DSP_G, DSP_B}. Bit 23 is shifted first.
- CRC-32: polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first, no reflection, no final XOR. It advances 24 bits per DE-high cycle.
- vs_fall: VSYNC_X sampled 0 while the registered previous sample is 1. de_fall is defined the same way on DE.
- State IDLE:
  - Internal counters and CRC are held at init.
  - Go to RUN on the first vs_fall while CHK_EN=1. That edge opens a frame; it produces no results.
- State RUN:
  - Each DE=1 cycle: wcnt+1 (saturates at 4095) and CRC update.
  - On de_fall: LINE_W←wcnt; ERR_W set if wcnt≠H_ACTIVE; lcnt+1 (saturates at 2047); wcnt←0.
  - On vs_fall:
    - FRAME_CRC←crc, LINE_CNT←lcnt.
    - ERR_H set if lcnt≠V_ACTIVE.
    - FRAME_CNT+1, wrapping from 0xFFFF to 0.
    - FRAME_DONE pulses.
    - crc, lcnt and wcnt return to init; stay in RUN.
  - vs_fall while DE=1: the open line is discarded (not counted, not in the CRC), ERR_W is set, and frame close proceeds as above.
  - CHK_EN=0: go to IDLE the next cycle. The result outputs and sticky errors hold.
- Sticky errors: ERR_CLR clears both. If a set and ERR_CLR land in the same cycle, the set wins.

## Timing
- Reset values: FRAME_DONE=0, FRAME_CRC=0, LINE_W=0, LINE_CNT=0, FRAME_CNT=0, ERR_W=0, ERR_H=0. State is IDLE and the previous-sample registers are 1.
- DRST mid-frame: everything returns to reset values on the next edge, and the partial frame is dropped.
- Cycle n is the cycle in which vs_fall is sampled. FRAME_DONE=1 and the updated FRAME_CRC/LINE_CNT/FRAME_CNT/ERR_H are visible in cycle n+1. FRAME_DONE is 0 again in n+2.
- LINE_W/ERR_W are visible one cycle after the cycle in which de_fall is sampled.
- Inputs are used directly and not re-registered. Total output latency is one register stage.
- There is no backpressure. FRAME_DONE is a fire-and-forget pulse.

## Structure
- Package disp_check_pkg holds:
  - CRC_POLY and CRC_INIT
  - width constants (12/11/16)
  - state enum {IDLE, RUN}
- Sub-module disp_crc32_d24: a combinational 24-bit-parallel next-CRC function (crc_in, data_in → crc_out), unrolled from the serial LFSR.
- The top level holds the edge detectors, counters, FSM and output registers.

## Test plan
- H_ACTIVE=4, V_ACTIVE=2, CHK_EN=1, three clean frames (2 lines × 4 DE cycles, pixels 0x000001..0x000008) → FRAME_DONE pulses twice (the first vs_fall only opens a frame). Expected after the second pulse:
  - LINE_W=4, LINE_CNT=2, FRAME_CNT=2
  - ERR_W=ERR_H=0
  - FRAME_CRC equals the bench bit-serial model of the 8 pixels.
- Same setup, second line has 5 DE cycles → LINE_W=5, ERR_W=1, ERR_H=0, with ERR_W visible one cycle after that de_fall.
- Frame with 3 lines → ERR_H=1 and LINE_CNT=3. ERR_CLR in the same cycle as the next ERR_H set → ERR_H stays 1. ERR_CLR alone later → both flags 0.
- vs_fall while DE=1 → ERR_W=1 and LINE_CNT excludes the open line.
- DRST asserted mid-line → all outputs 0 next cycle; FRAME_DONE is not seen until two vs_falls later.
- Preload via 65535 frames at tiny geometry → FRAME_CNT goes 0xFFFF → 0x0000.
